alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Multi-cycle, XLEN-parametrised integer execute unit for the RV core.
- Executes RV32I R-type (opcode 0110011) and I-type ALU (opcode 0010011) operations in one cycle.
- Optionally executes RV32M MUL/DIV/REM iteratively.
- Sits between decode/register-read and writeback, using a valid/ready handshake on both sides so multi-cycle ops can stall the pipeline.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, 32 or 64.
- SHW, $clog2(XLEN), shift-amount width; derived, never overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept an operation this cycle
- opcode_in  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- rs1_value_in  in  XLEN  source 1
- rs2_value_in  in  XLEN  source 2
- imm_value_in  in  XLEN  sign-extended immediate
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result_out  out  XLEN  registered result
- non_zero_out  out  1  OR-reduction of result_out
- illegal_out  out  1  accepted op was unsupported; qualified by out_valid
- busy  out  1  iterative operation in progress

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, result_out=0, illegal_out=0, busy=0, iteration counter=0.
- Reset mid-operation: aborts the op; no result is emitted.
- Accept: on in_valid && in_ready. All inputs are captured; inputs are don't-care afterwards.
- in_ready = (state==IDLE) && (!out_valid || out_ready). A back-to-back single-cycle stream therefore runs at 1 op/clk.
- Output hold: out_valid stays high and result_out/illegal_out stay stable until out_ready is sampled high.
- State IDLE:
  - Single-cycle op accepted -> result registered next edge; out_valid=1 (latency 1); remain IDLE.
  - M op accepted -> go to CALC with cnt=0 and busy=1.
- State CALC:
  - One quotient or multiplier bit per clk; cnt increments.
  - At cnt==XLEN-1 -> FIX.
- State FIX:
  - Apply sign correction and select the hi/lo half.
  - Go to DONE.
- State DONE:
  - out_valid=1, busy=0.
  - On out_ready -> IDLE.
- M-op latency: XLEN+2 clks from accept edge to out_valid (34 for XLEN=32).
- Operand selection: R-type uses src2=rs2; I-type uses src2=imm.
- ADD/SUB:
  - funct3=000.
  - SUB only when R-type && funct7==0100000.
  - ADDI never subtracts.
- SLL/SRL/SRA:
  - Shift amount is src2[SHW-1:0] for both R-type and I-type.
  - Arithmetic right shift when funct7[5]==1 (R-type) or imm[10]==1 (I-type), sign-filling from src1[XLEN-1]; otherwise zero-fill.
- SLT/SLTU:
  - Result is {XLEN-1 zeros, flag}.
  - Signed compare uses sign XOR overflow of src1-src2.
  - Unsigned compare uses the borrow.
- XOR/OR/AND: bitwise.
- Wrap-around: add/sub results truncate to XLEN; no flags are exported.
- Unsupported op: any other opcode, or an R-type funct7 not in {0000000, 0100000, [0000001 if M enabled]}, or SLLI/SRLI imm[11:5] illegal.
  - Result=0, illegal_out=1, latency 1.
- Simultaneous events:
  - out_ready with a new in_valid in the same cycle -> old result retires and the new op is accepted that edge.
  - reset has priority over everything.

Optional Feature:
- Macro: ALU_MC_MULDIV_EN.
- Defined: R-type with funct7==0000001 executes the M extension via CALC/FIX.
  - funct3 000-011: MUL, MULH, MULHSU, MULHU.
  - funct3 100-111: DIV, DIVU, REM, REMU.
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (-2^(XLEN-1) / -1): quotient = dividend; remainder = 0.
- Undefined: the CALC/FIX datapath and counter are not synthesised.
  - funct7==0000001 is treated as an unsupported op (latency 1, result 0, illegal_out=1).
  - busy is tied to 0.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, then SUB 5-7 back-to-back with out_ready=1 -> 0x80000000 then 0xFFFFFFFE on consecutive cycles; non_zero_out=1 both times.
- SRAI rs1=0x80000010, imm=0x40000404 (imm[10]=1, shamt=4) -> 0xF8000001; SRLI same rs1 with shamt=4 -> 0x08000001; SLT -1 vs 1 -> 1; SLTU -1 vs 1 -> 0.
- out_ready held low for 3 clks after an ADDI 0+0 result -> result_out=0, non_zero_out=0, out_valid stays high, in_ready=0; the next op is accepted in the same cycle out_ready rises.
- With ALU_MC_MULDIV_EN:
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 after 34 clks; MULHU same operands -> 0xFFFFFFFE.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - DIVU 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7.
- reset asserted at cnt==10 of a DIV -> next clk state IDLE, out_valid=0, busy=0, no result emitted; the following ADD 2+3 returns 5 with latency 1.
- opcode 0000011, and separately R-type funct7=0000001 without the macro -> illegal_out=1, result_out=0, latency 1.

Source files
------------

// File: rtl/alu_mc_if.sv
// Operation/result bus of the alu_mc execute unit.
// Both sides use strict valid/ready: a transfer happens on a rising clk edge where
// valid && ready; once valid is raised, the payload is held stable until that edge.
interface alu_mc_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode_in;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] rs1_value_in;
  logic [XLEN-1:0] rs2_value_in;
  logic [XLEN-1:0] imm_value_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result_out;
  logic            non_zero_out;
  logic            illegal_out;
  logic            busy;

  modport master (
    output in_valid, opcode_in, funct3, funct7, rs1_value_in, rs2_value_in, imm_value_in, out_ready,
    input  in_ready, out_valid, result_out, non_zero_out, illegal_out, busy
  );

  modport slave (
    input  in_valid, opcode_in, funct3, funct7, rs1_value_in, rs2_value_in, imm_value_in, out_ready,
    output in_ready, out_valid, result_out, non_zero_out, illegal_out, busy
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle integer execute unit: single-cycle RV32I ALU ops, plus iterative
// MUL/DIV/REM when ALU_MC_MULDIV_EN is defined. dbg_state exposes the FSM state.
module alu_mc #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic        clk,
  input  logic        reset,
  alu_mc_if.slave     bus,
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  state_t          state;
  logic            out_valid_q, illegal_q, in_ready, accept;
  logic [XLEN-1:0] result_q;

  logic            is_r, is_i, is_m, sub_op, arith_sh, illegal, slt_flag, sltu_flag;
  logic [XLEN-1:0] src1, src2, alu_res, sra_res;
  logic [XLEN:0]   diff;
  logic [SHW-1:0]  shamt;
  logic [11:0]     imm_chk;

  assign in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign dbg_state = state;

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.result_out   = result_q;
  assign bus.illegal_out  = illegal_q;
  assign bus.non_zero_out = |result_q;

  always_comb begin
    is_r     = (bus.opcode_in == 7'b0110011);
    is_i     = (bus.opcode_in == 7'b0010011);
    src1     = bus.rs1_value_in;
    src2     = is_r ? bus.rs2_value_in : bus.imm_value_in;
    shamt    = src2[SHW-1:0];
    sub_op   = is_r && (bus.funct7 == 7'b0100000) && (bus.funct3 == 3'b000);
    arith_sh = is_r ? bus.funct7[5] : bus.imm_value_in[10];
    // One subtractor serves SUB, SLT (sign ^ overflow) and SLTU (borrow = !carry).
    diff      = {1'b0, src1} + {1'b0, ~src2} + {{XLEN{1'b0}}, 1'b1};
    sltu_flag = ~diff[XLEN];
    slt_flag  = diff[XLEN-1] ^ ((src1[XLEN-1] != src2[XLEN-1]) && (diff[XLEN-1] != src1[XLEN-1]));
    sra_res   = XLEN'($signed(src1) >>> shamt);
    case (bus.funct3)
      3'b000:  alu_res = sub_op ? diff[XLEN-1:0] : src1 + src2;
      3'b001:  alu_res = src1 << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, slt_flag};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, sltu_flag};
      3'b100:  alu_res = src1 ^ src2;
      3'b101:  alu_res = arith_sh ? sra_res : src1 >> shamt;
      3'b110:  alu_res = src1 | src2;
      default: alu_res = src1 & src2;
    endcase
    is_m = 1'b0;
`ifdef ALU_MC_MULDIV_EN
    is_m = is_r && (bus.funct7 == 7'b0000001);
`endif
    // Shift immediates: everything above the shamt must be zero, except bit 10 on right shifts.
    imm_chk = bus.imm_value_in[11:0];
    imm_chk[SHW-1:0] = '0;
    if (bus.funct3 == 3'b101) imm_chk[10] = 1'b0;
    illegal = 1'b0;
    if (!is_r && !is_i)
      illegal = 1'b1;
    else if (is_r && !(bus.funct7 == 7'b0000000 || bus.funct7 == 7'b0100000 || is_m))
      illegal = 1'b1;
    else if (is_i && (bus.funct3 == 3'b001 || bus.funct3 == 3'b101) && imm_chk != 12'd0)
      illegal = 1'b1;
  end

`ifdef ALU_MC_MULDIV_EN
  logic              busy_q, neg_q, neg_r, div_zero, s1, s2, neg1, neg2;
  logic [SHW-1:0]    cnt;
  logic [2:0]        m_f3;
  logic [XLEN-1:0]   hi, lo, opnd, dividend, mag1, mag2, fix_res;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod;

  assign bus.busy = busy_q;

  always_comb begin
    s1   = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    s2   = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    neg1 = s1 && bus.rs1_value_in[XLEN-1];
    neg2 = s2 && bus.rs2_value_in[XLEN-1];
    mag1 = neg1 ? -bus.rs1_value_in : bus.rs1_value_in;
    mag2 = neg2 ? -bus.rs2_value_in : bus.rs2_value_in;
    // Multiply: shift-add into hi, multiplier bits leave lo from the bottom.
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    // Divide: restoring, dividend bits leave lo from the top, quotient bits enter at the bottom.
    div_sh   = {hi, lo[XLEN-1]};
    div_diff = div_sh - {1'b0, opnd};
    prod = {hi, lo};
    if (neg_q) prod = -prod;
    if (!m_f3[2])
      fix_res = (m_f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (div_zero)
      fix_res = m_f3[1] ? dividend : {XLEN{1'b1}};
    else if (m_f3[1])
      fix_res = neg_r ? -hi : hi;
    else
      fix_res = neg_q ? -lo : lo;
  end
`else
  assign bus.busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
`ifdef ALU_MC_MULDIV_EN
      busy_q      <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef ALU_MC_MULDIV_EN
          if (accept && is_m) begin
            state       <= CALC;
            busy_q      <= 1'b1;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            m_f3        <= bus.funct3;
            hi          <= '0;
            lo          <= bus.funct3[2] ? mag1 : mag2;
            opnd        <= bus.funct3[2] ? mag2 : mag1;
            dividend    <= bus.rs1_value_in;
            neg_q       <= neg1 ^ neg2;
            neg_r       <= neg1;
            div_zero    <= (bus.rs2_value_in == '0);
          end else
`endif
          if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= illegal ? '0 : alu_res;
            illegal_q   <= illegal;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
`ifdef ALU_MC_MULDIV_EN
        CALC: begin
          cnt <= cnt + SHW'(1);
          if (!m_f3[2]) begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end else if (!div_diff[XLEN]) begin
            hi <= div_diff[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b1};
          end else begin
            hi <= div_sh[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b0};
          end
          if (cnt == SHW'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          result_q    <= fix_res;
          illegal_q   <= 1'b0;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed + randomised bench for alu_mc; M-extension steps are compiled in
// only when ALU_MC_MULDIV_EN is defined, matching the RTL build.
module tb_alu_mc;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] F7_0 = 7'b0000000;
  localparam logic [6:0] F7_S = 7'b0100000;
  localparam logic [6:0] F7_M = 7'b0000001;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  alu_mc_if #(.XLEN(XLEN)) bus();
  alu_mc #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [XLEN-1:0] exp_q[$];
  logic            ill_q[$];
  int              lat_q[$];
  int              acc_q[$];
  logic            held = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 64'(bus.out_valid), 64'd0);
      end else begin
        if (!held) chk("latency", 64'(cyc - acc_q[0] + 1), 64'(lat_q[0]));
        if (bus.out_ready) begin
          chk("result", 64'(bus.result_out), 64'(exp_q[0]));
          chk("illegal", 64'(bus.illegal_out), 64'(ill_q[0]));
          chk("non_zero", 64'(bus.non_zero_out), 64'(exp_q[0] != '0));
          void'(exp_q.pop_front());
          void'(ill_q.pop_front());
          void'(lat_q.pop_front());
          void'(acc_q.pop_front());
          held = 1'b0;
        end else begin
          held = 1'b1;
        end
      end
    end else begin
      held = 1'b0;
    end
  end

  // driver: called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                       input logic [XLEN-1:0] er, input logic ei, input int el, output int waited);
    logic ok;
    ok = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.opcode_in = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.rs1_value_in = a;
    bus.rs2_value_in = b;
    bus.imm_value_in = imm;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
    end
    if (!ok) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    else begin
      @(posedge clk);
      #1;
      exp_q.push_back(er);
      ill_q.push_back(ei);
      lat_q.push_back(el);
      acc_q.push_back(cyc);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [XLEN-1:0] ref_op(input logic r, input logic [2:0] f3, input logic alt,
                                             input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    int sh;
    sh = int'(b[4:0]);
    case (f3)
      3'd0: res = (r && alt) ? a - b : a + b;
      3'd1: res = a << sh;
      3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: res = (a < b) ? 32'd1 : 32'd0;
      3'd4: res = a ^ b;
      3'd5: if (alt) res = 32'($signed(a) >>> sh); else res = a >> sh;
      3'd6: res = a | b;
      default: res = a & b;
    endcase
    return res;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic            r_sel, alt;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] a, b, imm, e;
  logic [11:0]     i12;
  int              w;

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.opcode_in = '0;
    bus.funct3 = '0;
    bus.funct7 = '0;
    bus.rs1_value_in = '0;
    bus.rs2_value_in = '0;
    bus.imm_value_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.result_out), 64'd0);
    chk("rst_illegal", 64'(bus.illegal_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // back-to-back ADD / SUB
    issue(OP_R, 3'b000, F7_0, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h8000_0000, 1'b0, 1, w);
    issue(OP_R, 3'b000, F7_S, 32'd5, 32'd7, 32'h0, 32'hFFFF_FFFE, 1'b0, 1, w);
    chk("b2b_wait", 64'(w), 64'd0);

    // shifts, compares, I-type corner cases
    issue(OP_I, 3'b101, F7_0, 32'h8000_0010, 32'h0, 32'h4000_0404, 32'hF800_0001, 1'b0, 1, w);
    issue(OP_I, 3'b101, F7_0, 32'h8000_0010, 32'h0, 32'h0000_0004, 32'h0800_0001, 1'b0, 1, w);
    issue(OP_R, 3'b010, F7_0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1, 1'b0, 1, w);
    issue(OP_R, 3'b011, F7_0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1, w);
    issue(OP_I, 3'b000, F7_S, 32'd10, 32'd99, 32'd3, 32'd13, 1'b0, 1, w);
    issue(OP_R, 3'b001, F7_0, 32'h1, 32'h23, 32'h0, 32'h8, 1'b0, 1, w);
    issue(OP_I, 3'b001, F7_0, 32'h1, 32'h0, 32'h0000_0404, 32'h0, 1'b1, 1, w);
    issue(OP_R, 3'b101, F7_S, 32'h8000_0000, 32'h1F, 32'h0, 32'hFFFF_FFFF, 1'b0, 1, w);

    // randomised legal R/I ALU ops
    for (int i = 0; i < 24; i++) begin
      r_sel = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      alt = (f3 == 3'd0 || f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
      a = $urandom;
      b = $urandom;
      if (r_sel) begin
        f7 = alt ? F7_S : F7_0;
        imm = $urandom;
        e = ref_op(1'b1, f3, alt, a, b);
        issue(OP_R, f3, f7, a, b, imm, e, 1'b0, 1, w);
      end else begin
        f7 = 7'($urandom_range(0, 127));
        i12 = 12'($urandom_range(0, 4095));
        if (f3 == 3'd1 || f3 == 3'd5) imm = (alt ? 32'h400 : 32'h0) | 32'($urandom_range(0, 31));
        else imm = {{20{i12[11]}}, i12};
        e = ref_op(1'b0, f3, alt, a, imm);
        issue(OP_I, f3, f7, a, b, imm, e, 1'b0, 1, w);
      end
    end
    drain();

    // output hold with out_ready low
    bus.out_ready = 1'b0;
    issue(OP_I, 3'b000, F7_0, 32'h0, 32'h5, 32'h0, 32'h0, 1'b0, 1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_result", 64'(bus.result_out), 64'd0);
      chk("hold_non_zero", 64'(bus.non_zero_out), 64'd0);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    issue(OP_R, 3'b100, F7_0, 32'hF0F0_0000, 32'h0FF0_00FF, 32'h0, 32'hFF00_00FF, 1'b0, 1, w);
    chk("hold_release_wait", 64'(w), 64'd0);

    // unsupported ops
    issue(7'b0000011, 3'b000, F7_0, 32'd1, 32'd2, 32'd3, 32'h0, 1'b1, 1, w);
    issue(OP_R, 3'b000, 7'b0010000, 32'd1, 32'd2, 32'd3, 32'h0, 1'b1, 1, w);
`ifdef ALU_MC_MULDIV_EN
    issue(OP_R, 3'b000, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 34, w);
    @(negedge clk);
    chk("m_busy", 64'(bus.busy), 64'd1);
    issue(OP_R, 3'b011, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 1'b0, 34, w);
    issue(OP_R, 3'b001, F7_M, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'hFFFF_FFFF, 1'b0, 34, w);
    issue(OP_R, 3'b010, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1'b0, 34, w);
    issue(OP_R, 3'b100, F7_M, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, w);
    issue(OP_R, 3'b110, F7_M, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 34, w);
    issue(OP_R, 3'b101, F7_M, 32'd7, 32'd0, 32'h0, 32'hFFFF_FFFF, 1'b0, 34, w);
    issue(OP_R, 3'b110, F7_M, 32'd7, 32'd0, 32'h0, 32'd7, 1'b0, 34, w);
    issue(OP_R, 3'b100, F7_M, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'hFFFF_FFFD, 1'b0, 34, w);
    issue(OP_R, 3'b110, F7_M, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'hFFFF_FFFF, 1'b0, 34, w);
    issue(OP_R, 3'b101, F7_M, 32'd100, 32'd7, 32'h0, 32'd14, 1'b0, 34, w);
    issue(OP_R, 3'b111, F7_M, 32'd100, 32'd7, 32'h0, 32'd2, 1'b0, 34, w);
    drain();

    // reset in the middle of a DIV
    issue(OP_R, 3'b100, F7_M, 32'd100, 32'd7, 32'h0, 32'd14, 1'b0, 34, w);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", 64'(bus.busy), 64'd1);
    chk("abort_state_before", 64'(dbg_state), 64'd1);
    reset = 1'b1;
    exp_q.delete();
    ill_q.delete();
    lat_q.delete();
    acc_q.delete();
    @(negedge clk);
    chk("abort_state", 64'(dbg_state), 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    chk("abort_no_result", 64'(bus.out_valid), 64'd0);
    issue(OP_R, 3'b000, F7_0, 32'd2, 32'd3, 32'h0, 32'd5, 1'b0, 1, w);
`else
    issue(OP_R, 3'b000, F7_M, 32'd6, 32'd7, 32'h0, 32'h0, 1'b1, 1, w);
    issue(OP_R, 3'b100, F7_M, 32'd100, 32'd7, 32'h0, 32'h0, 1'b1, 1, w);
    @(negedge clk);
    chk("no_m_busy", 64'(bus.busy), 64'd0);
`endif
    drain();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
